// File: rtl/seq_det_pkg.sv
// Shared types for the parametrised serial pattern detector.
// Optional overlapping detection: define SEQ_DET_OVERLAP_EN.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_SCAN = 2'd2,
    S_HIT  = 2'd3
  } seq_det_state_t;

  function automatic int FILL_W(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count holds at all-ones.
module seq_det_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loaded serial pattern detector with Moore match flag.
// Define SEQ_DET_OVERLAP_EN for overlapping detection.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PATTERN_LEN = 4,
  parameter int MATCH_CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cfg_load,
  input  logic [PATTERN_LEN-1:0] cfg_pattern,
  input  logic                   din,
  input  logic                   din_valid,
  output logic                   match,
  output logic [MATCH_CNT_W-1:0] match_count
);

  localparam int FW = FILL_W(PATTERN_LEN);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN);

  seq_det_state_t         r_state;
  seq_det_state_t         w_next;
  logic [PATTERN_LEN-1:0] r_pattern;
  // Only the newest LEN-1 bits are kept; din completes the window.
  logic [PATTERN_LEN-2:0] r_hist;
  logic [PATTERN_LEN-2:0] w_hist_nxt;
  logic [FW-1:0]          r_fill;
  logic [FW-1:0]          w_fill_nxt;
  logic [FW-1:0]          w_fill_inc;
  logic [PATTERN_LEN-1:0] w_shift;
  logic                   w_sample;
  logic                   w_hit;

  assign w_sample = din_valid & enable & ~cfg_load
                  & (r_state != S_IDLE);
  assign w_shift  = {r_hist, din};
  assign w_hit    = (w_shift == r_pattern);
  assign w_fill_inc = (r_fill == FULL) ? FULL
                                       : r_fill + FW'(1);

  always_comb begin
    w_next     = r_state;
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    if (cfg_load) begin
      w_next     = S_FILL;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_FILL: begin
          if (w_sample) begin
            w_hist_nxt = w_shift[PATTERN_LEN-2:0];
            w_fill_nxt = w_fill_inc;
            if (w_fill_inc == FULL)
              w_next = w_hit ? S_HIT : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_sample) begin
            w_hist_nxt = w_shift[PATTERN_LEN-2:0];
            w_fill_nxt = w_fill_inc;
            if (w_hit) w_next = S_HIT;
          end
        end
        S_HIT: begin
`ifdef SEQ_DET_OVERLAP_EN
          w_next = S_SCAN;
          if (w_sample) begin
            w_hist_nxt = w_shift[PATTERN_LEN-2:0];
            w_fill_nxt = w_fill_inc;
            if (w_hit) w_next = S_HIT;
          end
`else
          // A sample here opens a fresh window.
          w_next     = S_FILL;
          w_hist_nxt = '0;
          w_fill_nxt = '0;
          if (w_sample) begin
            w_hist_nxt = (PATTERN_LEN-1)'(din);
            w_fill_nxt = FW'(1);
          end
`endif
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pattern <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
    end else begin
      r_state <= w_next;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      if (cfg_load) r_pattern <= cfg_pattern;
    end
  end

  seq_det_sat_counter #(
    .WIDTH(MATCH_CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cfg_load),
    .inc   (w_next == S_HIT),
    .count (match_count)
  );

  assign match = (r_state == S_HIT);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: default counter width plus a 2-bit one.
// Expectations follow SEQ_DET_OVERLAP_EN when defined.
module tb_seq_detector_param;

  localparam int L = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic         cfg_load = 1'b0;
  logic [L-1:0] cfg_pattern = '0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         match, match2;
  logic [7:0]   cnt;
  logic [1:0]   cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  seq_detector_param #(.PATTERN_LEN(L), .MATCH_CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .enable(enable),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .din(din), .din_valid(din_valid),
    .match(match), .match_count(cnt)
  );

  seq_detector_param #(.PATTERN_LEN(L), .MATCH_CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .enable(enable),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .din(din), .din_valid(din_valid),
    .match(match2), .match_count(cnt2)
  );

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: list of accepted bits in the current window.
  bit         m_loaded;
  bit         m_q[$];
  bit [L-1:0] m_pat;
  bit         m_match;
  int         m_cnt8, m_cnt2;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_loaded = 0; m_q.delete(); m_pat = '0;
      m_match = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (cfg_load) begin
      m_loaded = 1; m_q.delete(); m_pat = cfg_pattern;
      m_match = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      bit hit;
      hit = 0;
      if (m_loaded && enable && din_valid) begin
        m_q.push_back(din);
        if (m_q.size() > L) void'(m_q.pop_front());
        if (m_q.size() == L) begin
          hit = 1;
          for (int i = 0; i < L; i++)
            if (m_q[i] != m_pat[L-1-i]) hit = 0;
        end
        if (hit && !OVL) m_q.delete();
      end
      m_match = hit;
      if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("match", match, m_match);
      chk("match_w2", match2, m_match);
      chk("count", cnt, m_cnt8);
      chk("count_w2", cnt2, m_cnt2);
    end
  end

  task automatic cyc(input logic ld, input logic [L-1:0] pat,
                     input logic v, input logic d);
    cfg_load = ld; cfg_pattern = pat; din_valid = v; din = d;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [L-1:0] pat);
    cyc(1'b1, pat, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      repeat (gap) cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, bits[i]);
    end
  endtask

  int hi;

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_match", match, 0);
    chk("reset_count", cnt, 0);

    // single pattern back-to-back
    load(4'b1011);
    feed(32'b1011, 4, 0);
    chk("t2_match", match, 1);
    chk("t2_count", cnt, 1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t2_drop", match, 0);

    // alternating stream
    load(4'b1010);
    feed(32'hAA, 8, 0);
    chk("t3_match", match, 1);
    chk("t3_count", cnt, OVL ? 3 : 2);

    // run of ones
    load(4'b1111);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b1);
      hi += int'(match);
    end
    chk("t4_highs", hi, OVL ? 3 : 1);
    chk("t4_count", cnt, OVL ? 3 : 1);

    // gaps between bits
    load(4'b1011);
    feed(32'b1011, 4, 3);
    chk("t5_match", match, 1);
    chk("t5_count", cnt, 1);

    // saturation of the narrow counter
    load(4'b1011);
    for (int k = 0; k < 5; k++) feed(32'b1011, 4, 0);
    chk("t6_sat", cnt2, 3);
    chk("t6_wide", cnt, 5);
    cyc(1'b1, 4'b1011, 1'b1, 1'b1);
    chk("t6_clr", cnt2, 0);
    chk("t6_clr_match", match2, 0);
    feed(32'b1011, 4, 0);
    chk("t6_refill", match2, 1);
    chk("t6_recount", cnt2, 1);

    // reset mid-stream
    load(4'b1011);
    for (int k = 0; k < 5; k++) feed(32'b1011, 4, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t1_pre_count", cnt, 5);
    #1 reset = 1'b1;
    #1;
    chk("t1_async_match", match, 0);
    chk("t1_async_count", cnt, 0);
    #1 reset = 1'b0;
    feed(32'hBB, 8, 0);
    chk("t1_idle_match", match, 0);
    chk("t1_idle_count", cnt, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(0, 9) != 0);
      cyc(($urandom_range(0, 149) == 0),
          L'($urandom_range(0, 15)),
          ($urandom_range(0, 9) < 7),
          1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
